// File: rtl/display_scan_ctrl.sv
// Multiplexed 7448 digit scanner: prescaled digit slots, dead-time blanking, leading-zero suppression.
// Optional build macro DISP_SCAN_DIM_EN adds a 2-bit dim input that trims the lit part of each slot.
module display_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 1000,
  parameter int DEAD     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic                    load,
  input  logic                    rbz_en,
  input  logic                    lt_n,
  input  logic                    bi_n,
`ifdef DISP_SCAN_DIM_EN
  input  logic [1:0]              dim,
`endif
  output logic [3:0]              bcd,
  output logic                    lt,
  output logic                    bi,
  output logic                    rbi,
  output logic [N_DIGITS-1:0]     dig_en,
  output logic                    frame_done
);

  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW  = $clog2(N_DIGITS);
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);
  localparam logic [PCW-1:0] PC_DEAD = PCW'(DEAD);
  localparam logic [IW-1:0]  IDX_TOP = IW'(N_DIGITS - 1);

  // scan state
  logic [PCW-1:0]          pc_reg, pc_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic [4*N_DIGITS-1:0]   pending_reg, pending_next;
  logic [4*N_DIGITS-1:0]   active_reg, active_next;

  // registered pins
  logic [3:0]              bcd_reg;
  logic                    lt_reg, bi_reg, rbi_reg, frame_done_reg;
  logic [N_DIGITS-1:0]     dig_en_reg;

  // combinational pin values, captured on the next edge
  logic [3:0]              bcd_next;
  logic                    bi_next, rbi_next;
  logic [N_DIGITS-1:0]     dig_en_next;

  logic                    tick;
  logic                    boundary;
  logic                    dim_ok;
  logic [3:0]              nib [N_DIGITS];
  logic [N_DIGITS-1:0]     lead_zero;

  assign tick     = (pc_reg == PC_LAST);
  assign boundary = tick && (idx_reg == '0);

  always_comb begin
    pc_next      = pc_reg + 1'b1;
    idx_next     = idx_reg;
    pending_next = pending_reg;
    active_next  = active_reg;
    if (tick) begin
      pc_next  = '0;
      idx_next = (idx_reg == '0) ? IDX_TOP : idx_reg - 1'b1;
    end
    if (load) begin
      pending_next = value;
    end
    // A load landing on the boundary edge bypasses pending so it is not lost for a frame.
    if (boundary) begin
      active_next = load ? value : pending_reg;
    end
  end

  // lead_zero[i]: every active nibble from the MSD down to i is zero
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign nib[gi]         = active_reg[4*gi +: 4];
      assign lead_zero[gi]   = ~|active_reg[4*N_DIGITS-1 : 4*gi];
      assign dig_en_next[gi] = (idx_reg != IW'(gi));
    end
  endgenerate

`ifdef DISP_SCAN_DIM_EN
  localparam int QUARTER = PRESCALE / 4;
  logic [31:0] dim_limit;
  assign dim_limit = 32'(PRESCALE) - 32'(dim) * 32'(QUARTER);
  assign dim_ok    = ({{(32-PCW){1'b0}}, pc_reg} < dim_limit);
`else
  assign dim_ok    = 1'b1;
`endif

  // Digit 0 is never suppressed, so an all-zero value still shows one "0".
  assign rbi_next = !(rbz_en && (idx_reg != '0) && lead_zero[idx_reg]);
  assign bcd_next = nib[idx_reg];
  assign bi_next  = bi_n && (pc_reg >= PC_DEAD) && dim_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= '0;
      idx_reg        <= IDX_TOP;
      pending_reg    <= '0;
      active_reg     <= '0;
      bcd_reg        <= '0;
      lt_reg         <= 1'b1;
      bi_reg         <= 1'b0;
      rbi_reg        <= 1'b1;
      dig_en_reg     <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      idx_reg        <= idx_next;
      pending_reg    <= pending_next;
      active_reg     <= active_next;
      bcd_reg        <= bcd_next;
      lt_reg         <= lt_n;
      bi_reg         <= bi_next;
      rbi_reg        <= rbi_next;
      dig_en_reg     <= dig_en_next;
      frame_done_reg <= boundary;
    end
  end

  assign bcd        = bcd_reg;
  assign lt         = lt_reg;
  assign bi         = bi_reg;
  assign rbi        = rbi_reg;
  assign dig_en     = dig_en_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (N_DIGITS=4, PRESCALE=4, DEAD=1): expected frames are queued
// by the stimulus, a monitor collects each 16-cycle frame up to frame_done and compares it.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        rbz_en = 1'b0;
  logic        lt_n = 1'b1;
  logic        bi_n = 1'b1;
`ifdef DISP_SCAN_DIM_EN
  logic [1:0]  dim = 2'd0;
`endif
  logic [3:0]  bcd;
  logic        lt, bi, rbi, frame_done;
  logic [3:0]  dig_en;

  display_scan_ctrl #(.N_DIGITS(4), .PRESCALE(4), .DEAD(1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .rbz_en(rbz_en),
    .lt_n(lt_n), .bi_n(bi_n),
`ifdef DISP_SCAN_DIM_EN
    .dim(dim),
`endif
    .bcd(bcd), .lt(lt), .bi(bi), .rbi(rbi), .dig_en(dig_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          tag;
    logic [15:0] digits;
    logic [3:0]  rbi;
    logic [3:0]  bi_pat;
    logic        lt;
  } exp_t;

  typedef struct packed {
    logic [3:0] dig_en;
    logic [3:0] bcd;
    logic       bi;
    logic       lt;
    logic       rbi;
  } smp_t;

  typedef struct packed {
    logic        rbz, bin, ltn;
    logic [1:0]  dm;
    int          off1;
    logic [15:0] v1;
    int          off2;
    logic [15:0] v2;
    logic [15:0] digits;
    logic [3:0]  rbi;
    logic [3:0]  bip;
    logic        lt;
  } frm_t;

  exp_t exp_q[$];
  smp_t smp_q[$];
  frm_t plan [13];
  int   total = 0;
  int   bad = 0;
  int   now = 0;
  logic [3:0] den_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic compare_frame(input exp_t e);
    for (int s = 0; s < 4; s++) begin
      int idx;
      idx = 3 - s;
      for (int c = 0; c < 4; c++) begin
        smp_t m;
        m = smp_q[4*s + c];
        check($sformatf("f%0d idx%0d c%0d dig_en", e.tag, idx, c), m.dig_en, den_tab[s]);
        check($sformatf("f%0d idx%0d c%0d bcd", e.tag, idx, c), m.bcd, e.digits[idx*4 +: 4]);
        check($sformatf("f%0d idx%0d c%0d rbi", e.tag, idx, c), m.rbi, e.rbi[idx]);
        check($sformatf("f%0d idx%0d c%0d bi", e.tag, idx, c), m.bi, e.bi_pat[c]);
        check($sformatf("f%0d idx%0d c%0d lt", e.tag, idx, c), m.lt, e.lt);
      end
    end
  endtask

  // Monitor: one frame is everything sampled up to and including the frame_done cycle.
  initial begin
    int   fcount;
    exp_t e;
    fcount = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        smp_q.delete();
        fcount = 0;
      end else begin
        smp_q.push_back('{dig_en, bcd, bi, lt, rbi});
        if (frame_done) begin
          check($sformatf("frame%0d_len", fcount), smp_q.size(), 16);
          if (exp_q.size() > 0 && exp_q[0].tag <= fcount) begin
            e = exp_q.pop_front();
            check("frame_tag", e.tag, fcount);
            if (smp_q.size() == 16) compare_frame(e);
          end
          fcount++;
          smp_q.delete();
        end else if (smp_q.size() > 16) begin
          check($sformatf("frame%0d_len", fcount), smp_q.size(), 16);
          smp_q.delete();
        end
      end
    end
  end

  task automatic adv(input int k);
    while (now < k - 1) begin
      @(negedge clk);
      now++;
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_dig_en"}, dig_en, 4'b1111);
    check({tag, "_bi"}, bi, 1'b0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_lt"}, lt, 1'b1);
    check({tag, "_rbi"}, rbi, 1'b1);
    check({tag, "_bcd"}, bcd, 4'h0);
  endtask

  initial begin
    exp_t e;
    //          rbz  bin  ltn  dm    off1 v1        off2 v2        digits    rbi      bip      lt
    plan[0]  = '{1'b0,1'b1,1'b1,2'd0, 8,  16'h1234, 0,   16'h0000, 16'h0000, 4'b1111, 4'b1110, 1'b1};
    plan[1]  = '{1'b0,1'b1,1'b1,2'd0, 0,  16'h0000, 0,   16'h0000, 16'h1234, 4'b1111, 4'b1110, 1'b1};
    plan[2]  = '{1'b1,1'b1,1'b1,2'd0, 8,  16'h0050, 0,   16'h0000, 16'h1234, 4'b1111, 4'b1110, 1'b1};
    plan[3]  = '{1'b1,1'b1,1'b1,2'd0, 8,  16'h0000, 0,   16'h0000, 16'h0050, 4'b0011, 4'b1110, 1'b1};
    plan[4]  = '{1'b1,1'b1,1'b1,2'd0, 0,  16'h0000, 0,   16'h0000, 16'h0000, 4'b0001, 4'b1110, 1'b1};
    plan[5]  = '{1'b0,1'b1,1'b1,2'd0, 8,  16'hABCD, 0,   16'h0000, 16'h0000, 4'b1111, 4'b1110, 1'b1};
    plan[6]  = '{1'b0,1'b1,1'b1,2'd0, 4,  16'h5678, 16,  16'h9012, 16'hABCD, 4'b1111, 4'b1110, 1'b1};
    plan[7]  = '{1'b0,1'b1,1'b1,2'd0, 0,  16'h0000, 0,   16'h0000, 16'h9012, 4'b1111, 4'b1110, 1'b1};
    plan[8]  = '{1'b0,1'b0,1'b0,2'd0, 0,  16'h0000, 0,   16'h0000, 16'h9012, 4'b1111, 4'b0000, 1'b0};
    plan[9]  = '{1'b0,1'b1,1'b0,2'd0, 0,  16'h0000, 0,   16'h0000, 16'h9012, 4'b1111, 4'b1110, 1'b0};
    plan[10] = '{1'b0,1'b1,1'b1,2'd0, 0,  16'h0000, 0,   16'h0000, 16'h9012, 4'b1111, 4'b1110, 1'b1};
`ifdef DISP_SCAN_DIM_EN
    plan[11] = '{1'b0,1'b1,1'b1,2'd2, 0,  16'h0000, 0,   16'h0000, 16'h9012, 4'b1111, 4'b0010, 1'b1};
`else
    plan[11] = '{1'b0,1'b1,1'b1,2'd2, 0,  16'h0000, 0,   16'h0000, 16'h9012, 4'b1111, 4'b1110, 1'b1};
`endif
    plan[12] = '{1'b0,1'b1,1'b1,2'd0, 8,  16'h7777, 0,   16'h0000, 16'h9012, 4'b1111, 4'b1110, 1'b1};

    repeat (3) @(negedge clk);
    check_reset_pins("por");
    rst_n = 1'b1;
    now = 0;

    for (int f = 0; f < 13; f++) begin
      adv(16*f + 1);
      rbz_en = plan[f].rbz;
      bi_n   = plan[f].bin;
      lt_n   = plan[f].ltn;
`ifdef DISP_SCAN_DIM_EN
      dim    = plan[f].dm;
`endif
      e = '{f, plan[f].digits, plan[f].rbi, plan[f].bip, plan[f].lt};
      exp_q.push_back(e);
      if (plan[f].off1 != 0) begin
        adv(16*f + plan[f].off1);
        value = plan[f].v1;
        load = 1'b1;
        adv(16*f + plan[f].off1 + 1);
        load = 1'b0;
      end
      if (plan[f].off2 != 0) begin
        adv(16*f + plan[f].off2);
        value = plan[f].v2;
        load = 1'b1;
        adv(16*f + plan[f].off2 + 1);
        load = 1'b0;
      end
    end

    // Mid-slot reset with 16'h7777 still pending: pins must drop without a clock edge.
    adv(215);
    check("pre_reset_bi", bi, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_pins("async");
    rbz_en = 1'b1;
    value  = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_pins("held");
    rst_n = 1'b1;
    now = 0;
    e = '{0, 16'h0000, 4'b0001, 4'b1110, 1'b1};
    exp_q.push_back(e);
    e = '{1, 16'h0000, 4'b0001, 4'b1110, 1'b1};
    exp_q.push_back(e);
    adv(36);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
